// File: rtl/adc_spi_pkg.sv
// ---------------------------------------------------------------------------
// adc_spi_pkg
// Constants and types for the ADC serial link. The ADC controller on the
// other end of the link uses the same package.
//   FRAME_BITS      : SCLK rising edges per frame
//   LEAD_ZEROS      : zero bits sent ahead of the sample
//   DATA_W          : sample width
//   NUM_CH / ADDR_W : channel count and channel address width
//   ADDR_FIRST_RISE : rising edge that carries the address MSB on DIN
// ---------------------------------------------------------------------------
package adc_spi_pkg;

   localparam int FRAME_BITS      = 16;
   localparam int LEAD_ZEROS      = 4;
   localparam int DATA_W          = 12;
   localparam int NUM_CH          = 8;
   localparam int ADDR_W          = 3;
   localparam int ADDR_FIRST_RISE = 3;

   // rcnt has to hold 0..FRAME_BITS inclusive
   localparam int RCNT_W = $clog2(FRAME_BITS + 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Word shifted out MSB-first: leading zeros, then the sample.
   function automatic logic [FRAME_BITS-1:0] frame_word(input logic [DATA_W-1:0] sample);
      return {{LEAD_ZEROS{1'b0}}, sample};
   endfunction

endpackage

// File: rtl/adc_spi_responder_if.sv
// ---------------------------------------------------------------------------
// adc_spi_responder_if
// The four-wire serial link between the ADC controller (master) and the
// responder (slave).
//   ADC_SCLK : serial clock, idles high (master -> slave)
//   ADC_CS_N : active-low chip select (master -> slave)
//   ADC_DIN  : address/config bits (master -> slave)
//   ADC_DOUT : sample data (slave -> master)
// ---------------------------------------------------------------------------
interface adc_spi_responder_if;

   logic ADC_SCLK;
   logic ADC_CS_N;
   logic ADC_DIN;
   logic ADC_DOUT;

   modport master (
      output ADC_SCLK,
      output ADC_CS_N,
      output ADC_DIN,
      input  ADC_DOUT
   );

   modport slave (
      input  ADC_SCLK,
      input  ADC_CS_N,
      input  ADC_DIN,
      output ADC_DOUT
   );

endinterface

// File: rtl/adc_in_sync.sv
// ---------------------------------------------------------------------------
// adc_in_sync
// Brings one asynchronous pin into the clk domain through a chain of
// SYNC_STAGES flops, then flags rising and falling edges of the synchronized
// level. Reset loads IDLE_VAL into every flop so the pin's idle level does
// not look like an edge.
//   clk, srst   : clock and synchronous active-high reset
//   pin         : asynchronous input
//   level       : synchronized level
//   rise, fall  : single-cycle edge flags, combinational from the registers
// ---------------------------------------------------------------------------
module adc_in_sync #(
   parameter int   SYNC_STAGES = 2,
   parameter logic IDLE_VAL    = 1'b0
) (
   input  logic clk,
   input  logic srst,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] stage_reg;
   logic [SYNC_STAGES-1:0] stage_next;
   logic                   prev_reg;

   genvar gi;
   generate
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            assign stage_next[gi] = pin;
         end else begin : g_chain
            assign stage_next[gi] = stage_reg[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (srst) begin
         stage_reg <= {SYNC_STAGES{IDLE_VAL}};
         prev_reg  <= IDLE_VAL;
      end else begin
         stage_reg <= stage_next;
         prev_reg  <= stage_reg[SYNC_STAGES-1];
      end
   end

   assign level = stage_reg[SYNC_STAGES-1];
   assign rise  =  level & ~prev_reg;
   assign fall  = ~level &  prev_reg;

endmodule

// File: rtl/adc_spi_responder.sv
// ---------------------------------------------------------------------------
// adc_spi_responder
// Slave side of the ADC serial link. Each frame is 16 SCLK rising edges.
// The master samples DOUT on its rising edges and sees 4 zeros followed by
// the 12-bit sample of ACTIVE_CH, MSB-first. While it does so, the master
// sends a channel address on DIN at rises 3..5. That address picks the
// channel for the next frame. If CS_N stays low after rise 16, the next
// SCLK fall starts a new frame (continuous mode).
//   CLOCK, RESET : system clock, synchronous active-high reset
//   CH0..CH7     : channel sample values
//   spi          : serial link (slave modport)
//   ACTIVE_CH    : channel being shifted out
//   FRAME_DONE   : one-cycle pulse on the 16th rise
//   FRAME_ERR    : one-cycle pulse when CS_N rises before the 16th rise
// ---------------------------------------------------------------------------
module adc_spi_responder
   import adc_spi_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic              CLOCK,
   input  logic              RESET,
   input  logic [DATA_W-1:0] CH0,
   input  logic [DATA_W-1:0] CH1,
   input  logic [DATA_W-1:0] CH2,
   input  logic [DATA_W-1:0] CH3,
   input  logic [DATA_W-1:0] CH4,
   input  logic [DATA_W-1:0] CH5,
   input  logic [DATA_W-1:0] CH6,
   input  logic [DATA_W-1:0] CH7,
   adc_spi_responder_if.slave spi,
   output logic [ADDR_W-1:0] ACTIVE_CH,
   output logic              FRAME_DONE,
   output logic              FRAME_ERR
);

   localparam logic [RCNT_W-1:0] RCNT_FULL = RCNT_W'(FRAME_BITS);
   localparam logic [RCNT_W-1:0] RCNT_ONE  = RCNT_W'(1);
   // The address bits arrive on rises ADDR_FIRST_RISE onward. rcnt is
   // compared before it is incremented, so the window starts one lower.
   localparam logic [RCNT_W-1:0] ADDR_LO   = RCNT_W'(ADDR_FIRST_RISE - 1);
   localparam logic [RCNT_W-1:0] ADDR_HI   = RCNT_W'(ADDR_FIRST_RISE - 1 + ADDR_W);

   // Pin vector order: bit 0 SCLK, bit 1 CS_N, bit 2 DIN
   localparam int          NUM_PINS = 3;
   localparam logic [2:0]  PIN_IDLE = 3'b011;

   logic [NUM_PINS-1:0] pin_raw;
   logic [NUM_PINS-1:0] pin_level;
   logic [NUM_PINS-1:0] pin_rise;
   logic [NUM_PINS-1:0] pin_fall;

   assign pin_raw = {spi.ADC_DIN, spi.ADC_CS_N, spi.ADC_SCLK};

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PINS; gi++) begin : g_sync
         adc_in_sync #(
            .SYNC_STAGES (SYNC_STAGES),
            .IDLE_VAL    (PIN_IDLE[gi])
         ) u_sync (
            .clk   (CLOCK),
            .srst  (RESET),
            .pin   (pin_raw[gi]),
            .level (pin_level[gi]),
            .rise  (pin_rise[gi]),
            .fall  (pin_fall[gi])
         );
      end
   endgenerate

   logic sclk_rise, sclk_fall, cs_rise, cs_fall, din_level;
   assign sclk_rise = pin_rise[0];
   assign sclk_fall = pin_fall[0];
   assign cs_rise   = pin_rise[1];
   assign cs_fall   = pin_fall[1];
   assign din_level = pin_level[2];

   // The remaining sync outputs are not needed by this block.
   logic unused_sync;
   assign unused_sync = ^{pin_level[1:0], pin_rise[2], pin_fall[2]};

   logic [DATA_W-1:0] ch_arr [NUM_CH];
   assign ch_arr[0] = CH0;
   assign ch_arr[1] = CH1;
   assign ch_arr[2] = CH2;
   assign ch_arr[3] = CH3;
   assign ch_arr[4] = CH4;
   assign ch_arr[5] = CH5;
   assign ch_arr[6] = CH6;
   assign ch_arr[7] = CH7;

   state_t                state_reg,      state_next;
   logic [RCNT_W-1:0]     rcnt_reg,       rcnt_next;
   logic [FRAME_BITS-1:0] sr_reg,         sr_next;
   logic [ADDR_W-1:0]     next_addr_reg,  next_addr_next;
   logic [ADDR_W-1:0]     active_ch_reg,  active_ch_next;
   logic                  frame_done_reg, frame_done_next;
   logic                  frame_err_reg,  frame_err_next;

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_reg      <= IDLE;
         rcnt_reg       <= '0;
         sr_reg         <= '0;
         next_addr_reg  <= '0;
         active_ch_reg  <= '0;
         frame_done_reg <= 1'b0;
         frame_err_reg  <= 1'b0;
      end else begin
         state_reg      <= state_next;
         rcnt_reg       <= rcnt_next;
         sr_reg         <= sr_next;
         next_addr_reg  <= next_addr_next;
         active_ch_reg  <= active_ch_next;
         frame_done_reg <= frame_done_next;
         frame_err_reg  <= frame_err_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      rcnt_next       = rcnt_reg;
      sr_next         = sr_reg;
      next_addr_next  = next_addr_reg;
      active_ch_next  = active_ch_reg;
      frame_done_next = 1'b0;
      frame_err_next  = 1'b0;

      case (state_reg)
         IDLE: begin
            // SCLK and DIN are ignored until the master selects us.
            if (cs_fall) begin
               sr_next        = frame_word(ch_arr[active_ch_reg]);
               rcnt_next      = '0;
               next_addr_next = '0;
               state_next     = SHIFT;
            end
         end

         SHIFT: begin
            // A CS_N rise takes priority over an SCLK edge in the same cycle.
            if (cs_rise) begin
               state_next     = IDLE;
               next_addr_next = '0;
               if (rcnt_reg != RCNT_FULL) begin
                  frame_err_next = 1'b1;
               end
            end else if (sclk_rise && (rcnt_reg != RCNT_FULL)) begin
               rcnt_next = rcnt_reg + RCNT_ONE;
               if ((rcnt_reg >= ADDR_LO) && (rcnt_reg < ADDR_HI)) begin
                  next_addr_next = {next_addr_reg[ADDR_W-2:0], din_level};
               end
               if (rcnt_reg == RCNT_FULL - RCNT_ONE) begin
                  frame_done_next = 1'b1;
                  active_ch_next  = next_addr_reg;
               end
            end else if (sclk_fall) begin
               if (rcnt_reg == RCNT_FULL) begin
                  // Continuous mode: this fall is fall 1 of the next frame.
                  // active_ch_reg was already updated on the 16th rise.
                  sr_next        = frame_word(ch_arr[active_ch_reg]);
                  rcnt_next      = '0;
                  next_addr_next = '0;
               end else if (rcnt_reg != '0) begin
                  // Fall 1 (rcnt 0) only precedes rise 1 and leaves the MSB
                  // in place. Falls 2..16 each expose the next bit.
                  sr_next = {sr_reg[FRAME_BITS-2:0], 1'b0};
               end
            end
         end

         default: state_next = IDLE;
      endcase
   end

   assign spi.ADC_DOUT = (state_reg == SHIFT) ? sr_reg[FRAME_BITS-1] : 1'b0;
   assign ACTIVE_CH    = active_ch_reg;
   assign FRAME_DONE   = frame_done_reg;
   assign FRAME_ERR    = frame_err_reg;

endmodule

// File: tb/tb_adc_spi_responder.sv
module tb_adc_spi_responder;
   import adc_spi_pkg::*;

   localparam int SS     = 2;
   localparam int HP_MIN = 2 * (SS + 1);

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [11:0] ch [8];
   logic [2:0]  active_ch;
   logic        frame_done;
   logic        frame_err;

   adc_spi_responder_if spi_if ();

   adc_spi_responder #(.SYNC_STAGES(SS)) dut (
      .CLOCK      (clk),
      .RESET      (rst),
      .CH0        (ch[0]),
      .CH1        (ch[1]),
      .CH2        (ch[2]),
      .CH3        (ch[3]),
      .CH4        (ch[4]),
      .CH5        (ch[5]),
      .CH6        (ch[6]),
      .CH7        (ch[7]),
      .spi        (spi_if),
      .ACTIVE_CH  (active_ch),
      .FRAME_DONE (frame_done),
      .FRAME_ERR  (frame_err)
   );

   int          n_tests   = 0;
   int          n_fail    = 0;
   int          done_cnt  = 0;
   int          err_cnt   = 0;
   bit          both_seen = 1'b0;
   int          hp        = 8;
   logic [15:0] exp_q [$];

   // Pulse monitor
   always @(negedge clk) begin
      if (frame_done) done_cnt++;
      if (frame_err)  err_cnt++;
      if (frame_done && frame_err) both_seen = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
      $display("[TB] %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // n SCLK cycles; DIN carries addr MSB-first on rises 3..5, DOUT is
   // sampled at each rising pin edge.
   task automatic sclk_cycles(input int n, input logic [2:0] addr, output logic [15:0] word);
      word = '0;
      for (int k = 1; k <= n; k++) begin
         spi_if.ADC_SCLK = 1'b0;
         if (k >= 3 && k <= 5) spi_if.ADC_DIN = addr[5-k];
         else                  spi_if.ADC_DIN = 1'b0;
         wait_clks(hp);
         spi_if.ADC_SCLK = 1'b1;
         word = {word[14:0], spi_if.ADC_DOUT};
         wait_clks(hp);
      end
   endtask

   task automatic frame_start;
      spi_if.ADC_CS_N = 1'b0;
      wait_clks(hp);
   endtask

   task automatic frame_end;
      spi_if.ADC_CS_N = 1'b1;
      wait_clks(2 * hp);
   endtask

   task automatic expect_frame(input logic [2:0] exp_ch);
      exp_q.push_back({4'h0, ch[exp_ch]});
   endtask

   task automatic pop_check(input string tag, input logic [15:0] word);
      logic [15:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      check(tag, {16'h0, word}, {16'h0, e});
   endtask

   task automatic full_frame(input string tag, input logic [2:0] addr, input logic [2:0] exp_ch);
      int d0;
      logic [15:0] w;
      expect_frame(exp_ch);
      d0 = done_cnt;
      frame_start();
      sclk_cycles(16, addr, w);
      pop_check(tag, w);
      check({tag, "_done"}, done_cnt - d0, 1);
      frame_end();
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, e0;
      logic [15:0] w1, w2;
      logic [2:0] exp_act, a;

      spi_if.ADC_SCLK = 1'b1;
      spi_if.ADC_CS_N = 1'b1;
      spi_if.ADC_DIN  = 1'b0;
      for (int i = 0; i < 8; i++) ch[i] = '0;
      rst = 1'b1;
      wait_clks(5);
      check("rst_dout",  spi_if.ADC_DOUT, 0);
      check("rst_active", active_ch, 0);
      check("rst_done",  frame_done, 0);
      check("rst_err",   frame_err, 0);
      rst = 1'b0;
      wait_clks(5);

      // Basic frame, CH0
      ch[0] = 12'hABC;
      full_frame("f000", 3'b000, 3'd0);
      check("f000_active", active_ch, 0);

      // Address 101 selects CH5 for the next frame
      ch[5] = 12'h5A5;
      full_frame("f101_a", 3'b101, 3'd0);
      check("f101_active", active_ch, 5);
      full_frame("f101_b", 3'b000, 3'd5);
      check("f101_b_active", active_ch, 0);
      check("idle_dout", spi_if.ADC_DOUT, 0);

      // Abort after 9 rises
      e0 = err_cnt; d0 = done_cnt;
      frame_start();
      sclk_cycles(9, 3'b011, w1);
      frame_end();
      check("abort_err", err_cnt - e0, 1);
      check("abort_done", done_cnt - d0, 0);
      check("abort_active", active_ch, 0);
      check("abort_dout", spi_if.ADC_DOUT, 0);

      // Continuous mode: two frames without releasing CS_N
      ch[0] = 12'h001; ch[7] = 12'hFFF;
      expect_frame(3'd0);
      expect_frame(3'd7);
      d0 = done_cnt;
      frame_start();
      sclk_cycles(16, 3'b111, w1);
      sclk_cycles(16, 3'b000, w2);
      frame_end();
      pop_check("cont_1", w1);
      pop_check("cont_2", w2);
      check("cont_done", done_cnt - d0, 2);
      check("cont_active", active_ch, 0);

      // Reset mid-frame with ACTIVE_CH = 6
      ch[0] = 12'h3C5; ch[6] = 12'h666;
      full_frame("pre_rst", 3'b110, 3'd0);
      check("pre_rst_active", active_ch, 6);
      e0 = err_cnt;
      frame_start();
      sclk_cycles(8, 3'b010, w1);
      rst = 1'b1;
      wait_clks(3);
      spi_if.ADC_CS_N = 1'b1;
      spi_if.ADC_SCLK = 1'b1;
      spi_if.ADC_DIN  = 1'b0;
      wait_clks(4);
      rst = 1'b0;
      wait_clks(2 * hp);
      check("rst_mid_err", err_cnt - e0, 0);
      check("rst_mid_active", active_ch, 0);
      check("rst_mid_dout", spi_if.ADC_DOUT, 0);
      full_frame("post_rst", 3'b000, 3'd0);

      // Minimum-rate SCLK, random data and addresses
      hp = HP_MIN;
      exp_act = 3'd0;
      for (int i = 0; i < 100; i++) begin
         for (int c = 0; c < 8; c++) ch[c] = 12'($urandom_range(0, 4095));
         a = 3'($urandom_range(0, 7));
         full_frame($sformatf("rnd%0d", i), a, exp_act);
         exp_act = a;
      end
      check("rnd_active", active_ch, {29'h0, exp_act});

      check("never_both", both_seen, 0);
      check("sb_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/adc_spi_responder.md
ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, which sets the synchronizer depth on ADC_SCLK, ADC_CS_N and ADC_DIN (minimum 2).
REQ-002 SHALL have port CLOCK, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port RESET, input, 1 bit: reset, synchronous to CLOCK and active-high.
REQ-004 SHALL have ports CH0..CH7, input, 12 bits each: the sample values presented for channels 0..7.
REQ-005 SHALL have port ADC_SCLK, input, 1 bit: serial clock from the external master; idles high.
REQ-006 SHALL have port ADC_CS_N, input, 1 bit: active-low chip select from the master.
REQ-007 SHALL have port ADC_DIN, input, 1 bit: serial address/config bits from the master.
REQ-008 SHALL have port ADC_DOUT, output, 1 bit: serial sample data driven to the master.
REQ-009 SHALL have port ACTIVE_CH, output, 3 bits: the channel being shifted out in the current frame.
REQ-010 SHALL have port FRAME_DONE, output, 1 bit: one-CLOCK pulse when a frame of 16 rising edges completes.
REQ-011 SHALL have port FRAME_ERR, output, 1 bit: one-CLOCK pulse when ADC_CS_N rises before a frame completes.

Function
REQ-012 SHALL synchronize ADC_SCLK, ADC_CS_N and ADC_DIN through SYNC_STAGES flops, then detect edges on the synchronized signals; a pin edge SHALL act internally within SYNC_STAGES+1 CLOCK cycles.
REQ-013 SHALL operate correctly when each ADC_SCLK half-period is at least 2*(SYNC_STAGES+1) CLOCK cycles; behaviour outside this limit is unspecified.
REQ-014 SHALL implement states IDLE and SHIFT, with a rising-edge counter rcnt (0..16) and a 16-bit shift register SR.
REQ-015 SHALL, in IDLE on a detected ADC_CS_N fall, load SR = {4'b0000, CH[ACTIVE_CH]}, clear rcnt and enter SHIFT; the channel value is sampled once per frame.
REQ-016 SHALL drive ADC_DOUT = SR[15] while in SHIFT, and 0 while in IDLE.
REQ-017 SHALL ignore the 1st detected ADC_SCLK fall of a frame and shift SR left by one on falls 2..16, so that the master's rising edge k sees bit 16-k.
REQ-018 SHALL, as a consequence of REQ-017, present 4 leading zeros followed by the 12-bit data MSB-first.
REQ-019 SHALL increment rcnt on each detected ADC_SCLK rise in SHIFT, and SHALL capture ADC_DIN on rises 3, 4 and 5 into NEXT_ADDR[2:0] MSB-first.
REQ-020 SHALL, on the 16th rise, pulse FRAME_DONE and set ACTIVE_CH <= NEXT_ADDR, so the captured address selects the next frame's channel.
REQ-021 SHALL support continuous mode: if ADC_CS_N remains low after the 16th rise, the next detected ADC_SCLK fall SHALL reload SR from the new ACTIVE_CH and begin a new frame.
REQ-022 SHALL, in continuous mode, treat that reloading fall as fall 1 of the new frame, with rcnt restarting at 0.
REQ-023 SHALL, on a detected ADC_CS_N rise with rcnt < 16, pulse FRAME_ERR, leave ACTIVE_CH unchanged, discard NEXT_ADDR and return to IDLE.
REQ-024 SHALL, on a detected ADC_CS_N rise with rcnt == 16, return to IDLE without pulsing FRAME_ERR.
REQ-025 SHALL give a ADC_CS_N rise priority when it is detected in the same CLOCK cycle as an ADC_SCLK edge; that SCLK edge is ignored.
REQ-026 SHALL ignore ADC_SCLK and ADC_DIN activity while in IDLE.
REQ-027 SHALL never assert FRAME_DONE and FRAME_ERR in the same CLOCK cycle.

Reset
REQ-028 SHALL, while RESET is high, force: state IDLE, rcnt 0, SR 0, NEXT_ADDR 0, ACTIVE_CH 0, ADC_DOUT 0, FRAME_DONE 0, FRAME_ERR 0, and all synchronizer stages to idle levels (SCLK 1, CS_N 1, DIN 0).
REQ-029 SHALL, when RESET is asserted mid-frame, abandon the frame without a FRAME_ERR pulse; after release, a new frame starts only on the next detected ADC_CS_N fall.

Structure
REQ-030 SHALL take the constants FRAME_BITS=16, LEAD_ZEROS=4, DATA_W=12, NUM_CH=8, ADDR_W=3 and ADDR_FIRST_RISE=3 from the shared package adc_spi_pkg, which the existing ADC controller shares.
REQ-031 SHALL instantiate one sub-module, adc_in_sync (synchronizer plus rise/fall detect), once per input pin.

Verification
REQ-032 Reset then a frame with DIN address bits = 000: bench samples 0x0ABC on rises 5..16 with CH0=0xABC, and sees 0 on rises 1..4.
REQ-033 Frame 1 with DIN address 101, then frame 2 with CH5=0x5A5: frame 2 returns 0x5A5 and ACTIVE_CH reads 5 after the frame 1 FRAME_DONE.
REQ-034 ADC_CS_N raised after 9 rises with address 011: exactly one FRAME_ERR pulse, ACTIVE_CH stays 0, ADC_DOUT returns to 0.
REQ-035 Continuous mode, 32 SCLK cycles with CS_N held low, CH0=0x001 and CH7=0xFFF, first frame address 111: two FRAME_DONE pulses, returning 0x001 then 0xFFF.
REQ-036 RESET pulsed at rise 8 with a prior ACTIVE_CH of 6: no FRAME_ERR, ACTIVE_CH = 0, and the next frame returns CH0.
REQ-037 Minimum-rate SCLK (half-period 2*(SYNC_STAGES+1) CLOCK cycles) with random CH values over 100 frames: every bit matches.
